fnd_controller: RTL

- Downstream display stage for the stopwatch.
- Consumes the binary msec/sec/min/hour time fields and drives the Basys3 4-digit common-anode 7-segment display by time-multiplexed scanning.
- Takes a per-frame snapshot of its inputs so that no frame ever shows mixed old and new values.
- Selects between a SS.CC view and an HH.MM view, and blinks the centre decimal point at 1 Hz from msec.

---
 rtl/fnd_pkg.sv | 24 ++
 rtl/fnd_seg_decoder.sv | 27 ++
 rtl/fnd_controller.sv | 111 +++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the stopwatch 7-segment display stage.
// Segment codes are {dp,g,f,e,d,c,b,a}, active-low, with the dp off.
package fnd_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam int unsigned NUM_DIGITS = 4;

   localparam logic [6:0] MSEC_MAX = 7'd99;
   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/fnd_seg_decoder.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal inputs blank the digit.
module fnd_seg_decoder
   import fnd_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK[6:0];
      case (bcd)
         4'd0:    seg = SEG_0[6:0];
         4'd1:    seg = SEG_1[6:0];
         4'd2:    seg = SEG_2[6:0];
         4'd3:    seg = SEG_3[6:0];
         4'd4:    seg = SEG_4[6:0];
         4'd5:    seg = SEG_5[6:0];
         4'd6:    seg = SEG_6[6:0];
         4'd7:    seg = SEG_7[6:0];
         4'd8:    seg = SEG_8[6:0];
         4'd9:    seg = SEG_9[6:0];
         default: seg = SEG_BLANK[6:0];
      endcase
   end

endmodule

// File: rtl/fnd_controller.sv
// Scanned 4-digit common-anode display driver with a per-frame input snapshot,
// SS.CC / HH.MM view select and a 1 Hz centre decimal point.
module fnd_controller
   import fnd_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] msec,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hour,
   input  logic       sw_mode,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);

   localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
   localparam logic [1:0] LastDigit = 2'(NUM_DIGITS - 1);

   logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]      digit_sel_q, digit_sel_d;
   logic            tick;

   logic [6:0] snap_msec_q, snap_msec_d;
   logic [5:0] snap_sec_q, snap_sec_d;
   logic [5:0] snap_min_q, snap_min_d;
   logic [4:0] snap_hour_q, snap_hour_d;
   logic       snap_mode_q, snap_mode_d;

   logic [NUM_DIGITS-1:0][3:0] digit;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] fnd_com_d;
   logic [7:0] fnd_data_d;

   assign tick = (scan_cnt_q == CntMax);

   always_comb begin
      scan_cnt_d  = tick ? '0 : scan_cnt_q + CntW'(1);
      digit_sel_d = tick ? digit_sel_q + 2'd1 : digit_sel_q;

      snap_msec_d = snap_msec_q;
      snap_sec_d  = snap_sec_q;
      snap_min_d  = snap_min_q;
      snap_hour_d = snap_hour_q;
      snap_mode_d = snap_mode_q;
      // Inputs are only sampled at the frame boundary so a frame never mixes values.
      if (tick && digit_sel_q == LastDigit) begin
         snap_msec_d = (msec > MSEC_MAX) ? MSEC_MAX : msec;
         snap_sec_d  = (sec  > SEC_MAX)  ? SEC_MAX  : sec;
         snap_min_d  = (min  > MIN_MAX)  ? MIN_MAX  : min;
         snap_hour_d = (hour > HOUR_MAX) ? HOUR_MAX : hour;
         snap_mode_d = sw_mode;
      end
   end

   always_comb begin
      if (snap_mode_q) begin
         digit[3] = 4'(snap_hour_q / 5'd10);
         digit[2] = 4'(snap_hour_q % 5'd10);
         digit[1] = 4'(snap_min_q / 6'd10);
         digit[0] = 4'(snap_min_q % 6'd10);
      end else begin
         digit[3] = 4'(snap_sec_q / 6'd10);
         digit[2] = 4'(snap_sec_q % 6'd10);
         digit[1] = 4'(snap_msec_q / 7'd10);
         digit[0] = 4'(snap_msec_q % 7'd10);
      end
   end

   fnd_seg_decoder u_seg_decoder (
      .bcd (digit[digit_sel_q]),
      .seg (seg)
   );

   // Centre dp is lit for the first half of every second.
   assign dp = !((digit_sel_q == 2'd2) && (snap_msec_q < 7'd50));

   always_comb begin
      fnd_com_d  = ~(4'b0001 << digit_sel_q);
      fnd_data_d = {dp, seg};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q  <= '0;
         digit_sel_q <= 2'd0;
         snap_msec_q <= '0;
         snap_sec_q  <= '0;
         snap_min_q  <= '0;
         snap_hour_q <= '0;
         snap_mode_q <= 1'b0;
         fnd_com     <= 4'b1111;
         fnd_data    <= SEG_BLANK;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         digit_sel_q <= digit_sel_d;
         snap_msec_q <= snap_msec_d;
         snap_sec_q  <= snap_sec_d;
         snap_min_q  <= snap_min_d;
         snap_hour_q <= snap_hour_d;
         snap_mode_q <= snap_mode_d;
         fnd_com     <= fnd_com_d;
         fnd_data    <= fnd_data_d;
      end
   end

endmodule
